// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every KxK window of a row-major image held in
// the input SRAM, issues one read per tap and streams the returned pixels to
// the MAC array with valid/ready and window first/last markers.
// Optional feature macro: CONV_SEQ_ZERO_PAD_EN (zero padding of K/2 per side).
module conv_window_sequencer #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 10,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 3,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_first,
  output logic                  pix_last
);

`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam int PAD = K / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT_W  = (IMG_W + 2 * PAD - K) / STRIDE + 1;
  localparam int OUT_H  = (IMG_H + 2 * PAD - K) / STRIDE + 1;
  localparam int DIM_MX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW     = $clog2(DIM_MX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic           vld_q, vld_d, first_q, first_d, last_q, last_d;
  logic           issue, kx_end, ky_end, ox_end, oy_end;
  logic signed [31:0] tx, ty;

  // Current tap position in image coordinates (may be negative when padding).
  assign tx = int'(ox_q) * STRIDE + int'(kx_q) - PAD;
  assign ty = int'(oy_q) * STRIDE + int'(ky_q) - PAD;

  assign kx_end = (kx_q == CW'(K - 1));
  assign ky_end = (ky_q == CW'(K - 1));
  assign ox_end = (ox_q == CW'(OUT_W - 1));
  assign oy_end = (oy_q == CW'(OUT_H - 1));

  // A tap issues only when the output slot is free or being drained this cycle.
  assign issue = (state_q == S_RUN) && (!vld_q || pix_ready);

`ifdef CONV_SEQ_ZERO_PAD_EN
  logic pad_q, pad_d, in_img;

  assign in_img        = (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_H);
  assign mem_read_req  = issue && in_img;
  assign mem_read_addr = in_img ? ADDR_WIDTH'(ty * IMG_W + tx) : '0;
  assign pix_data      = pad_q ? '0 : mem_read_data;
  assign pad_d         = issue ? !in_img : pad_q;

  // Pad flag travels with the beat so a stalled padded tap keeps reading as 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pad_q <= 1'b0;
    else       pad_q <= pad_d;
  end
`else
  assign mem_read_req  = issue;
  assign mem_read_addr = ADDR_WIDTH'(ty * IMG_W + tx);
  assign pix_data      = mem_read_data;
`endif

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pix_valid = vld_q;
  assign pix_first = first_q;
  assign pix_last  = last_q;

  // Next-state: FSM sequencing, tap counters and output beat qualifiers.
  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    vld_d   = issue || (vld_q && !pix_ready);
    first_d = first_q;
    last_d  = last_q;

    if (issue) begin
      first_d = (kx_q == '0) && (ky_q == '0);
      last_d  = kx_end && ky_end;
    end else if (!vld_d) begin
      first_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (issue) begin
          if (kx_end) begin
            kx_d = '0;
            if (ky_end) begin
              ky_d = '0;
              if (ox_end) begin
                ox_d = '0;
                if (oy_end) begin
                  oy_d    = '0;
                  state_d = S_DRAIN;
                end else begin
                  oy_d = oy_q + CW'(1);
                end
              end else begin
                ox_d = ox_q + CW'(1);
              end
            end else begin
              ky_d = ky_q + CW'(1);
            end
          end else begin
            kx_d = kx_q + CW'(1);
          end
        end
      end
      S_DRAIN: if (vld_q && pix_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and beat registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule
